// File: rtl/dcache_pkg.sv
// Shared types, width helpers and tree-PLRU functions for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_WBACK,
    S_REFILL
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Way indices and PLRU state are sized for the largest legal associativity.
  localparam int MAX_WAYS  = 4;
  localparam int WAY_IDX_W = 2;
  localparam int PLRU_W    = 3;

  localparam int DEF_LINE_BITS = 256;
  localparam int DEF_SETS      = 16;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_OFF_W     = clog2(DEF_LINE_BITS / 8);
  localparam int DEF_IDX_W     = clog2(DEF_SETS);
  localparam int DEF_TAG_W     = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;

  // PLRU bits point at the victim side; touching a way points them away from it.
  // 4-way: bit0 = root (0 -> ways 0/1), bit1 = pair 0/1, bit2 = pair 2/3.
  function automatic logic [PLRU_W-1:0] plru_touch(input int ways,
                                                   input logic [PLRU_W-1:0] st,
                                                   input logic [WAY_IDX_W-1:0] way);
    logic [PLRU_W-1:0] nxt;
    nxt = st;
    if (ways == 2) begin
      nxt[0] = ~way[0];
    end else if (ways == 4) begin
      nxt[0] = ~way[1];
      if (way[1]) nxt[2] = ~way[0];
      else        nxt[1] = ~way[0];
    end
    return nxt;
  endfunction

  function automatic logic [WAY_IDX_W-1:0] plru_victim(input int ways,
                                                       input logic [PLRU_W-1:0] st);
    logic [WAY_IDX_W-1:0] v;
    v = '0;
    if (ways == 2) begin
      v = {1'b0, st[0]};
    end else if (ways == 4) begin
      v = st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
    end
    return v;
  endfunction

endpackage

// File: rtl/dcache_way_store.sv
// One cache way: valid/dirty bits, tags and line data, async read, sync line and word writes.
module dcache_way_store
  import dcache_pkg::*;
#(
  parameter int SETS      = 16,
  parameter int TAG_W     = 23,
  parameter int LINE_BITS = 256,
  parameter int DATA_W    = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [clog2(SETS)-1:0]            idx_i,
  output logic                              rd_valid_o,
  output logic                              rd_dirty_o,
  output logic [TAG_W-1:0]                  rd_tag_o,
  output logic [LINE_BITS-1:0]              rd_line_o,
  input  logic                              line_we_i,
  input  logic [TAG_W-1:0]                  line_tag_i,
  input  logic [LINE_BITS-1:0]              line_data_i,
  input  logic                              word_we_i,
  input  logic [clog2(LINE_BITS/DATA_W)-1:0] word_sel_i,
  input  logic [DATA_W-1:0]                 word_data_i
);

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tags and data are never cleared; the valid bit qualifies them.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i*DATA_W +: DATA_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_assoc_top.sv
// N-way write-back, write-allocate data cache with tree-PLRU replacement and hit/miss counters.
module dcache_assoc_top
  import dcache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [DATA_W-1:0]    p1_data_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [DATA_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  localparam int OFF_W  = clog2(LINE_BITS / 8);
  localparam int IDX_W  = clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS  = LINE_BITS / DATA_W;
  localparam int WORD_W = clog2(WORDS);

  state_t state_q, state_d;

  logic [TAG_W-1:0]     cpu_tag;
  logic [IDX_W-1:0]     cpu_idx;
  logic [WORD_W-1:0]    cpu_word;
  logic [IDX_W-1:0]     rd_idx;
  logic                 req, hit, miss_start, refill_done;
  logic [MAX_WAYS-1:0]  match;
  logic [WAY_IDX_W-1:0] hit_way, victim_way;

  logic [MAX_WAYS-1:0]  rd_valid, rd_dirty;
  logic [TAG_W-1:0]     rd_tag  [MAX_WAYS];
  logic [LINE_BITS-1:0] rd_line [MAX_WAYS];

  logic [TAG_W-1:0]     miss_tag_q;
  logic [IDX_W-1:0]     miss_idx_q;
  logic [WAY_IDX_W-1:0] miss_way_q;
  logic [PLRU_W-1:0]    plru_q [SETS];

  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, p1_addr_i[1:0]};

  assign cpu_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_idx  = p1_addr_i[OFF_W +: IDX_W];
  assign cpu_word = p1_addr_i[2 +: WORD_W];
  assign req      = p1_MemRead_i | p1_MemWrite_i;

  // Outside IDLE the arrays are addressed by the latched miss index so a wandering CPU address cannot disturb the fill.
  assign rd_idx = (state_q == S_IDLE) ? cpu_idx : miss_idx_q;

  generate
    for (genvar w = 0; w < MAX_WAYS; w++) begin : g_way
      if (w < WAYS) begin : g_inst
        dcache_way_store #(
          .SETS      (SETS),
          .TAG_W     (TAG_W),
          .LINE_BITS (LINE_BITS),
          .DATA_W    (DATA_W)
        ) u_way (
          .clk_i       (clk_i),
          .rst_i       (rst_i),
          .idx_i       (rd_idx),
          .rd_valid_o  (rd_valid[w]),
          .rd_dirty_o  (rd_dirty[w]),
          .rd_tag_o    (rd_tag[w]),
          .rd_line_o   (rd_line[w]),
          .line_we_i   (refill_done && (miss_way_q == WAY_IDX_W'(w))),
          .line_tag_i  (miss_tag_q),
          .line_data_i (mem_data_i),
          .word_we_i   (hit && p1_MemWrite_i && (hit_way == WAY_IDX_W'(w))),
          .word_sel_i  (cpu_word),
          .word_data_i (p1_data_i)
        );
      end else begin : g_none
        assign rd_valid[w] = 1'b0;
        assign rd_dirty[w] = 1'b0;
        assign rd_tag[w]   = '0;
        assign rd_line[w]  = '0;
      end
    end
  endgenerate

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < MAX_WAYS; w++) begin
      if (w < WAYS && rd_valid[w] && rd_tag[w] == cpu_tag) begin
        match[w] = 1'b1;
        hit_way  = WAY_IDX_W'(w);
      end
    end
  end

  assign hit         = req && (state_q == S_IDLE) && (|match);
  assign miss_start  = req && (state_q == S_IDLE) && !hit;
  assign refill_done = (state_q == S_REFILL) && mem_ack_i;
  assign p1_stall_o  = req & ~hit;
  assign p1_data_o   = hit ? rd_line[hit_way][cpu_word*DATA_W +: DATA_W] : '0;

  // Lowest-numbered invalid way wins; otherwise the PLRU choice.
  always_comb begin
    victim_way = plru_victim(WAYS, plru_q[cpu_idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valid[w]) victim_way = WAY_IDX_W'(w);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (miss_start) state_d = S_MISS;
      S_MISS:   state_d = (rd_valid[miss_way_q] && rd_dirty[miss_way_q]) ? S_WBACK : S_REFILL;
      S_WBACK:  if (mem_ack_i) state_d = S_REFILL;
      S_REFILL: if (mem_ack_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory request outputs are registered so they stay stable for the whole transfer.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
    end else begin
      case (state_q)
        S_MISS: begin
          mem_enable_o <= 1'b1;
          if (rd_valid[miss_way_q] && rd_dirty[miss_way_q]) begin
            mem_write_o <= 1'b1;
            mem_addr_o  <= {rd_tag[miss_way_q], miss_idx_q, {OFF_W{1'b0}}};
          end else begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
          end
        end
        S_WBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
          end
        end
        S_REFILL: begin
          if (mem_ack_i) mem_enable_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (miss_start) begin
      miss_tag_q <= cpu_tag;
      miss_idx_q <= cpu_idx;
      miss_way_q <= victim_way;
    end
    if (state_q == S_MISS) mem_data_o <= rd_line[miss_way_q];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      if (hit) begin
        hit_cnt_o       <= hit_cnt_o + 32'd1;
        plru_q[cpu_idx] <= plru_touch(WAYS, plru_q[cpu_idx], hit_way);
      end
      if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end

  a_single_match: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(match));

endmodule

// File: tb/tb_dcache_assoc_top.sv
// Directed bench: a 2-way cache and a direct-mapped cache, each backed by a fixed-latency memory model.
module tb_dcache_assoc_top;

  logic clk;
  logic rst_i;

  logic [255:0] a_mem_rdata, a_mem_wdata;
  logic         a_ack_auto, a_ack_man, a_mem_ack;
  logic [31:0]  a_mem_addr;
  logic         a_mem_en, a_mem_wr;
  logic [31:0]  a_wdata, a_addr, a_dout, a_hit_cnt, a_miss_cnt;
  logic         a_rd, a_wr, a_stall;

  logic [255:0] b_mem_rdata, b_mem_wdata;
  logic         b_ack_auto, b_mem_ack;
  logic [31:0]  b_mem_addr;
  logic         b_mem_en, b_mem_wr;
  logic [31:0]  b_wdata, b_addr, b_dout, b_hit_cnt, b_miss_cnt;
  logic         b_rd, b_wr, b_stall;

  int n_cmp = 0;
  int n_err = 0;

  assign a_mem_ack = a_ack_auto | a_ack_man;
  assign b_mem_ack = b_ack_auto;

  dcache_assoc_top #(.WAYS(2), .SETS(16), .LINE_BITS(256), .ADDR_W(32), .DATA_W(32)) u_dut_a (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mem_data_i   (a_mem_rdata),
    .mem_ack_i    (a_mem_ack),
    .mem_data_o   (a_mem_wdata),
    .mem_addr_o   (a_mem_addr),
    .mem_enable_o (a_mem_en),
    .mem_write_o  (a_mem_wr),
    .p1_data_i    (a_wdata),
    .p1_addr_i    (a_addr),
    .p1_MemRead_i (a_rd),
    .p1_MemWrite_i(a_wr),
    .p1_data_o    (a_dout),
    .p1_stall_o   (a_stall),
    .hit_cnt_o    (a_hit_cnt),
    .miss_cnt_o   (a_miss_cnt)
  );

  dcache_assoc_top #(.WAYS(1), .SETS(16), .LINE_BITS(256), .ADDR_W(32), .DATA_W(32)) u_dut_b (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mem_data_i   (b_mem_rdata),
    .mem_ack_i    (b_mem_ack),
    .mem_data_o   (b_mem_wdata),
    .mem_addr_o   (b_mem_addr),
    .mem_enable_o (b_mem_en),
    .mem_write_o  (b_mem_wr),
    .p1_data_i    (b_wdata),
    .p1_addr_i    (b_addr),
    .p1_MemRead_i (b_rd),
    .p1_MemWrite_i(b_wr),
    .p1_data_o    (b_dout),
    .p1_stall_o   (b_stall),
    .hit_cnt_o    (b_hit_cnt),
    .miss_cnt_o   (b_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word i of the line at address A reads 0xC0DE0000 | A[15:0] | i.
  function automatic logic [255:0] line_pat(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hC0DE0000 | {16'h0, a[15:0]} | 32'(i);
    return l;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory models: ack LAT cycles after the request is seen, one-cycle pulse.
  int           a_lat = 10, a_cnt = 0, a_wb_n = 0, a_rf_n = 0;
  bit           a_hold = 1'b0;
  logic [31:0]  a_wb_addr = '0, a_rf_addr = '0;
  logic [255:0] a_wb_data = '0;

  always @(negedge clk) begin
    if (a_ack_auto) begin
      a_ack_auto = 1'b0;
      a_cnt      = 0;
    end else if (!a_mem_en || a_hold) begin
      a_cnt = 0;
    end else begin
      a_cnt++;
      if (a_cnt >= a_lat) begin
        a_ack_auto = 1'b1;
        if (a_mem_wr) begin
          a_wb_n++;
          a_wb_addr = a_mem_addr;
          a_wb_data = a_mem_wdata;
        end else begin
          a_rf_n++;
          a_rf_addr   = a_mem_addr;
          a_mem_rdata = line_pat(a_mem_addr);
        end
      end
    end
  end

  int           b_lat = 2, b_cnt = 0, b_wb_n = 0;
  logic [31:0]  b_rf_addr = '0;

  always @(negedge clk) begin
    if (b_ack_auto) begin
      b_ack_auto = 1'b0;
      b_cnt      = 0;
    end else if (!b_mem_en) begin
      b_cnt = 0;
    end else begin
      b_cnt++;
      if (b_cnt >= b_lat) begin
        b_ack_auto = 1'b1;
        if (b_mem_wr) begin
          b_wb_n++;
        end else begin
          b_rf_addr   = b_mem_addr;
          b_mem_rdata = line_pat(b_mem_addr);
        end
      end
    end
  end

  // One CPU access: hold the request until the stall drops, sample data before the completing edge.
  task automatic cpu_op(input bit sel, input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int stalls,
                        output logic [31:0] hits_now);
    @(negedge clk);
    if (sel) begin
      b_addr = addr; b_rd = rd; b_wr = wr; b_wdata = wdata;
    end else begin
      a_addr = addr; a_rd = rd; a_wr = wr; a_wdata = wdata;
    end
    stalls = 0;
    #1;
    while ((sel ? b_stall : a_stall) && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 200) check_val("stall_timeout", 32'(stalls), 32'd0);
    rdata    = sel ? b_dout : a_dout;
    hits_now = sel ? b_hit_cnt : a_hit_cnt;
    @(posedge clk);
    #1;
    if (sel) begin b_rd = 1'b0; b_wr = 1'b0; end
    else     begin a_rd = 1'b0; a_wr = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata, hits;
    int          st;
    rst_i = 1'b0;
    a_ack_auto = 1'b0; a_ack_man = 1'b0; a_mem_rdata = '0;
    b_ack_auto = 1'b0; b_mem_rdata = '0;
    a_addr = '0; a_wdata = '0; a_rd = 1'b0; a_wr = 1'b0;
    b_addr = '0; b_wdata = '0; b_rd = 1'b0; b_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check_val("rst_mem_en", 32'(a_mem_en), 32'd0);
    check_val("rst_mem_wr", 32'(a_mem_wr), 32'd0);
    check_val("rst_mem_addr", a_mem_addr, 32'd0);
    check_val("rst_hit_cnt", a_hit_cnt, 32'd0);
    check_val("rst_miss_cnt", a_miss_cnt, 32'd0);
    check_val("rst_stall", 32'(a_stall), 32'd0);

    // Cold read, 10-cycle memory.
    cpu_op(1'b0, 32'h040, 1'b1, 1'b0, 32'h0, rdata, st, hits);
    check_val("cold_stall", 32'(st), 32'd12);
    check_val("cold_data", rdata, 32'hC0DE0040);
    check_val("cold_rf_addr", a_rf_addr, 32'h040);
    check_val("cold_rf_n", 32'(a_rf_n), 32'd1);
    check_val("cold_miss_cnt", a_miss_cnt, 32'd1);
    check_val("cold_hit_cnt", a_hit_cnt, 32'd1);

    a_lat = 3;
    cpu_op(1'b0, 32'h044, 1'b0, 1'b1, 32'hDEADBEEF, rdata, st, hits);
    check_val("st_hit_stall", 32'(st), 32'd0);
    cpu_op(1'b0, 32'h044, 1'b1, 1'b0, 32'h0, rdata, st, hits);
    check_val("ld_hit_stall", 32'(st), 32'd0);
    check_val("ld_hit_data", rdata, 32'hDEADBEEF);
    check_val("ld_hit_cnt", hits, 32'd2);

    // Fill way 1, touch way 0, then 0x440 evicts clean way 1.
    cpu_op(1'b0, 32'h240, 1'b1, 1'b0, 32'h0, rdata, st, hits);
    check_val("w1_stall", 32'(st), 32'd5);
    check_val("w1_data", rdata, 32'hC0DE0240);
    check_val("w1_rf_addr", a_rf_addr, 32'h240);
    cpu_op(1'b0, 32'h040, 1'b1, 1'b0, 32'h0, rdata, st, hits);
    check_val("w0_again_stall", 32'(st), 32'd0);
    check_val("w0_again_data", rdata, 32'hC0DE0040);
    cpu_op(1'b0, 32'h440, 1'b1, 1'b0, 32'h0, rdata, st, hits);
    check_val("ev_clean_stall", 32'(st), 32'd5);
    check_val("ev_clean_rf_addr", a_rf_addr, 32'h440);
    check_val("ev_clean_wb_n", 32'(a_wb_n), 32'd0);

    // 0x240 now evicts the dirty 0x040 line.
    cpu_op(1'b0, 32'h240, 1'b1, 1'b0, 32'h0, rdata, st, hits);
    check_val("ev_dirty_stall", 32'(st), 32'd9);
    check_val("ev_dirty_wb_n", 32'(a_wb_n), 32'd1);
    check_val("ev_dirty_wb_addr", a_wb_addr, 32'h040);
    check_val("ev_dirty_wb_w1", a_wb_data[63:32], 32'hDEADBEEF);
    check_val("ev_dirty_wb_w0", a_wb_data[31:0], 32'hC0DE0040);
    check_val("ev_dirty_rf_addr", a_rf_addr, 32'h240);
    check_val("ev_dirty_data", rdata, 32'hC0DE0240);
    check_val("ev_dirty_miss_cnt", a_miss_cnt, 32'd4);
    check_val("ev_dirty_hit_cnt", a_hit_cnt, 32'd7);

    // Read and write together behave as a store; read data is the pre-store word.
    cpu_op(1'b0, 32'h048, 1'b1, 1'b1, 32'h12345678, rdata, st, hits);
    check_val("rw_stall", 32'(st), 32'd5);
    check_val("rw_rf_addr", a_rf_addr, 32'h040);
    check_val("rw_old_data", rdata, 32'hC0DE0042);
    check_val("rw_wb_n", 32'(a_wb_n), 32'd1);
    cpu_op(1'b0, 32'h048, 1'b1, 1'b0, 32'h0, rdata, st, hits);
    check_val("rw_read_stall", 32'(st), 32'd0);
    check_val("rw_read_data", rdata, 32'h12345678);

    // Reset in the middle of a refill; a late ack must be ignored.
    a_hold = 1'b1;
    @(negedge clk);
    a_addr = 32'h840; a_rd = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("mid_mem_en", 32'(a_mem_en), 32'd1);
    check_val("mid_mem_wr", 32'(a_mem_wr), 32'd0);
    check_val("mid_mem_addr", a_mem_addr, 32'h840);
    rst_i = 1'b0;
    a_rd  = 1'b0;
    @(negedge clk);
    rst_i     = 1'b1;
    a_ack_man = 1'b1;
    #1;
    check_val("mrst_mem_en", 32'(a_mem_en), 32'd0);
    check_val("mrst_mem_addr", a_mem_addr, 32'd0);
    check_val("mrst_hit_cnt", a_hit_cnt, 32'd0);
    check_val("mrst_miss_cnt", a_miss_cnt, 32'd0);
    @(negedge clk);
    a_ack_man = 1'b0;
    #1;
    check_val("late_ack_mem_en", 32'(a_mem_en), 32'd0);
    check_val("late_ack_miss_cnt", a_miss_cnt, 32'd0);
    a_hold = 1'b0;
    cpu_op(1'b0, 32'h040, 1'b1, 1'b0, 32'h0, rdata, st, hits);
    check_val("post_rst_stall", 32'(st), 32'd5);
    check_val("post_rst_data", rdata, 32'hC0DE0040);
    check_val("post_rst_miss_cnt", a_miss_cnt, 32'd1);
    check_val("post_rst_hit_cnt", a_hit_cnt, 32'd1);

    // Direct-mapped: 0x040 and 0x240 share set 2 and keep evicting each other.
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b1, (i % 2 == 1) ? 32'h240 : 32'h040, 1'b1, 1'b0, 32'h0, rdata, st, hits);
      check_val("dm_stall", 32'(st), 32'd4);
      check_val("dm_data", rdata, (i % 2 == 1) ? 32'hC0DE0240 : 32'hC0DE0040);
    end
    check_val("dm_miss_cnt", b_miss_cnt, 32'd4);
    check_val("dm_wb_n", 32'(b_wb_n), 32'd0);
    check_val("dm_rf_addr", b_rf_addr, 32'h240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
